uart_frame_arbiter: RTL and testbench
=====================================

# uart_frame_arbiter

Round-robin scheduler that shares the single UART transmit FIFO write port (`UART_tx_interface`) among four packet sources. Each granted source's payload is wrapped in a frame: header, source ID, length, payload, 8-bit additive checksum. Bytes are pushed one per cycle whenever the TX FIFO is not full. The block sits between the data packagers (telemetry, RC, status) and `UART_tx_interface`, replacing per-source direct FIFO writes.

## Interface

- `HEADER`, default 8'hAA: frame start byte.
- `MAXLEN`, default 16: maximum payload bytes. Larger requested lengths are clamped to this value.
- `CLK`, in, 1: system clock, 50 MHz.
- `RSTn`, in, 1: asynchronous active-low reset.
- `Req`, in, 4: per-source frame request, level. Must be held until the matching `Done` bit pulses.
- `Len`, in, 20: packed 5-bit payload lengths; source k uses `Len[5k+4:5k]`, range 0..31. Sampled at grant.
- `Pay_Dat`, in, 32: packed payload bytes; source k drives `Pay_Dat[8k+7:8k]` = its byte at index `Rd_Idx`.
- `Grant`, out, 4: one-hot, registered. High for the whole frame of the served source.
- `Rd_Idx`, out, 4: payload byte index being read, 0..MAXLEN-1.
- `Done`, out, 4: one-cycle pulse on the served source's bit when its frame is fully written.
- `Full_sig`, in, 1: TX FIFO full flag.
- `WR_Req_sig`, out, 1: TX FIFO write strobe. Combinational.
- `FIFO_WR_Dat`, out, 8: byte to write. Combinational, valid whenever `WR_Req_sig` is high.

## Operation

- FSM states: IDLE, HDR, ID, LEN, PAY, CSUM, DONE. Reset state is IDLE.
- **IDLE**
  - If any `Req` bit is high, grant the first requester found searching upward (wrapping) from `rr_ptr`.
  - At the same edge: latch `len_q` = min(Len[g], MAXLEN), clear `Rd_Idx` and `sum`, set `Grant`, go to HDR.
- **Emit states** (HDR, ID, LEN, PAY, CSUM):
  - `WR_Req_sig` = !Full_sig.
  - The state advances only on an edge where `WR_Req_sig` = 1. If `Full_sig` = 1 the state holds and the byte is retried.
- **Bytes written per state:**
  - HDR: `HEADER`.
  - ID: {6'b0, g}.
  - LEN: {3'b0, len_q}.
  - PAY: `Pay_Dat[8g+7:8g]`.
  - CSUM: `sum`.
- **Checksum:** `sum` is the modulo-256 sum of the ID byte, the LEN byte and every payload byte, updated on each accepted write. The header byte is excluded.
- **Length handling:**
  - LEN goes to PAY, or directly to CSUM if `len_q` = 0.
  - In PAY, each accepted byte increments `Rd_Idx`. After byte `len_q`-1, go to CSUM.
- **After CSUM:** go to DONE.
- **DONE:** `Done[g]` = 1 for one cycle, `Grant` cleared, `rr_ptr` = g+1 mod 4, go to IDLE.
- **Mid-frame request changes:** `Req` deasserted mid-frame is ignored and the frame completes. New requests wait for IDLE.
- **Reset values:** `Grant` = 0, `Done` = 0, `Rd_Idx` = 0, `rr_ptr` = 0, `sum` = 0, `WR_Req_sig` = 0, `FIFO_WR_Dat` = 0.
- **Reset mid-frame:** the frame is aborted immediately and no further writes occur. The FIFO keeps the partial frame; the receiver resynchronises on `HEADER`.

## Timing

- Req high at IDLE edge n: `Grant` and the HDR write appear in cycle n+1.
- With `Full_sig` held at 0, a frame takes len_q+4 write cycles, then 1 DONE cycle, then 1 IDLE cycle. Back-to-back frames therefore start len_q+6 cycles apart.
- `Rd_Idx` changes only on accepted PAY writes. Sources must present `Pay_Dat` combinationally for the current `Rd_Idx`, stable while `Grant` is high.
- `Full_sig` rising in the same cycle as a write suppresses that write. No byte is lost or duplicated.
- Round-robin guarantees that a held request is served within 3 other frames.

## Test plan

- **Single source, no stall:** Req=4'b0001, Len0=3, payload 11,22,33 with `Full_sig`=0.
  - FIFO receives AA,00,03,11,22,33,69.
  - `Done`=4'b0001 in cycle 8 after the Req edge.
- **All four requesting:** Req=4'b1111 held, Len=1 each.
  - Grant order is 0,1,2,3,0.
  - Each frame is 5 bytes, and successive HDR writes are 7 cycles apart.
- **FIFO stall:** `Full_sig`=1 for 5 cycles while in PAY at index 1.
  - `WR_Req_sig` stays 0 throughout the stall and `Rd_Idx` holds at 1.
  - The byte stream is identical to the no-stall case.
- **Zero and clamped lengths:**
  - Len=0 from source 2 gives AA,02,00,02.
  - Len=20 from source 3 gives a LEN byte of 0x10 and 16 payload bytes.
- **Checksum wrap:** source 1, Len=2, payload FF,FF.
  - Checksum = (01+02+FF+FF) mod 256 = 0x01.
- **Reset mid-frame:** assert RSTn=0 during PAY.
  - All outputs go to 0 immediately.
  - After release with Req=4'b0001 still held, source 0 is granted first and a complete new frame is emitted.

Source files
------------

// File: rtl/uart_frame_arbiter.sv
// Round-robin arbiter that frames packets from four sources onto the shared UART TX FIFO write port.
// Frame layout: HEADER, source ID, length, payload bytes, 8-bit additive checksum (header excluded).
module uart_frame_arbiter #(
    parameter logic [7:0] HEADER = 8'hAA,
    parameter int         MAXLEN = 16
) (
    input  logic        CLK,
    input  logic        RSTn,
    input  logic [3:0]  Req,
    input  logic [19:0] Len,
    input  logic [31:0] Pay_Dat,
    output logic [3:0]  Grant,
    output logic [3:0]  Rd_Idx,
    output logic [3:0]  Done,
    input  logic        Full_sig,
    output logic        WR_Req_sig,
    output logic [7:0]  FIFO_WR_Dat
);

    localparam logic [2:0] IDLE = 3'd0;
    localparam logic [2:0] HDR  = 3'd1;
    localparam logic [2:0] ID   = 3'd2;
    localparam logic [2:0] LEN  = 3'd3;
    localparam logic [2:0] PAY  = 3'd4;
    localparam logic [2:0] CSUM = 3'd5;
    localparam logic [2:0] DONE = 3'd6;

    localparam logic [4:0] MAXLEN_L = 5'(MAXLEN);

    logic [2:0] state;
    logic [1:0] gnt_idx;
    logic [1:0] rr_ptr;
    logic [1:0] pick;
    logic [4:0] len_q;
    logic [7:0] sum;
    logic [4:0] len_raw;
    logic [4:0] len_clamp;
    logic [7:0] pay_byte;
    logic       req_any;
    logic       emit;
    logic       last_pay;

    // Scan downward so the requester closest above rr_ptr is the last (winning) assignment.
    always_comb begin
        pick = rr_ptr;
        for (int i = 3; i >= 0; i--) begin
            if (Req[rr_ptr + 2'(i)]) begin
                pick = rr_ptr + 2'(i);
            end
        end
    end

    assign req_any = |Req;

    always_comb begin
        case (pick)
            2'd0:    len_raw = Len[4:0];
            2'd1:    len_raw = Len[9:5];
            2'd2:    len_raw = Len[14:10];
            default: len_raw = Len[19:15];
        endcase
    end

    assign len_clamp = (len_raw > MAXLEN_L) ? MAXLEN_L : len_raw;

    always_comb begin
        case (gnt_idx)
            2'd0:    pay_byte = Pay_Dat[7:0];
            2'd1:    pay_byte = Pay_Dat[15:8];
            2'd2:    pay_byte = Pay_Dat[23:16];
            default: pay_byte = Pay_Dat[31:24];
        endcase
    end

    assign emit       = (state == HDR) || (state == ID) || (state == LEN) ||
                        (state == PAY) || (state == CSUM);
    assign WR_Req_sig = emit && !Full_sig;
    assign last_pay   = ({1'b0, Rd_Idx} == (len_q - 5'd1));

    // Data is presented for the whole emit state so a stalled byte is simply retried.
    always_comb begin
        case (state)
            HDR:     FIFO_WR_Dat = HEADER;
            ID:      FIFO_WR_Dat = {6'b0, gnt_idx};
            LEN:     FIFO_WR_Dat = {3'b0, len_q};
            PAY:     FIFO_WR_Dat = pay_byte;
            CSUM:    FIFO_WR_Dat = sum;
            default: FIFO_WR_Dat = 8'h00;
        endcase
    end

    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            state   <= IDLE;
            gnt_idx <= 2'd0;
            rr_ptr  <= 2'd0;
            len_q   <= 5'd0;
            sum     <= 8'h00;
            Rd_Idx  <= 4'd0;
            Grant   <= 4'b0000;
            Done    <= 4'b0000;
        end else begin
            Done <= 4'b0000;
            case (state)
                IDLE: begin
                    if (req_any) begin
                        gnt_idx <= pick;
                        Grant   <= 4'b0001 << pick;
                        len_q   <= len_clamp;
                        Rd_Idx  <= 4'd0;
                        sum     <= 8'h00;
                        state   <= HDR;
                    end
                end
                HDR: begin
                    if (WR_Req_sig) begin
                        state <= ID;
                    end
                end
                ID: begin
                    if (WR_Req_sig) begin
                        sum   <= sum + FIFO_WR_Dat;
                        state <= LEN;
                    end
                end
                LEN: begin
                    if (WR_Req_sig) begin
                        sum   <= sum + FIFO_WR_Dat;
                        state <= (len_q == 5'd0) ? CSUM : PAY;
                    end
                end
                PAY: begin
                    if (WR_Req_sig) begin
                        sum    <= sum + FIFO_WR_Dat;
                        Rd_Idx <= Rd_Idx + 4'd1;
                        if (last_pay) begin
                            state <= CSUM;
                        end
                    end
                end
                CSUM: begin
                    if (WR_Req_sig) begin
                        Done  <= Grant;
                        state <= DONE;
                    end
                end
                DONE: begin
                    Grant  <= 4'b0000;
                    rr_ptr <= gnt_idx + 2'd1;
                    state  <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_frame_arbiter.sv
// Scoreboard bench for uart_frame_arbiter: a frame-level model queues expected bytes and Done pulses,
// and a monitor compares them against every FIFO write and Done pulse the DUT produces.
module tb_uart_frame_arbiter;

    localparam logic [7:0] HEADER = 8'hAA;
    localparam int         MAXLEN = 16;

    logic        CLK = 1'b0;
    logic        RSTn;
    logic [3:0]  Req;
    logic [19:0] Len;
    logic [31:0] Pay_Dat;
    logic [3:0]  Grant;
    logic [3:0]  Rd_Idx;
    logic [3:0]  Done;
    logic        Full_sig;
    logic        WR_Req_sig;
    logic [7:0]  FIFO_WR_Dat;

    typedef struct packed {
        logic [7:0] dat;
        logic [1:0] src;
        logic       hdr;
        logic       pay;
        logic [3:0] idx;
    } exp_t;

    exp_t       exp_q[$];
    int         done_q[$];
    int         hdr_cyc_q[$];
    int         done_cyc_q[$];
    logic [7:0] pay_mem [4][16];
    int         len_cfg [4];
    int         rem_cfg [4];
    int         drv_rem [4];
    int         model_ptr;
    int         cyc = 0;
    int         n_vectors = 0;
    int         n_miscompares = 0;
    int         stall_left;
    bit         stall_done;
    bit         reset_done;
    int         round_start;

    uart_frame_arbiter #(.HEADER(HEADER), .MAXLEN(MAXLEN)) dut (
        .CLK        (CLK),
        .RSTn       (RSTn),
        .Req        (Req),
        .Len        (Len),
        .Pay_Dat    (Pay_Dat),
        .Grant      (Grant),
        .Rd_Idx     (Rd_Idx),
        .Done       (Done),
        .Full_sig   (Full_sig),
        .WR_Req_sig (WR_Req_sig),
        .FIFO_WR_Dat(FIFO_WR_Dat)
    );

    initial forever #5 CLK = ~CLK;

    always @(posedge CLK) cyc <= cyc + 1;

    // Each source answers combinationally with its byte at the current read index.
    for (genvar k = 0; k < 4; k++) begin : g_src
        assign Pay_Dat[8*k +: 8] = pay_mem[k][Rd_Idx];
    end

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] req);
        n_vectors++;
        if (act !== req) begin
            n_miscompares++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, req, $time);
        end
    endtask

    // Frame model: header, id, clamped length, payload, mod-256 sum of id+len+payload.
    function automatic void push_frame(input int src);
        int   l;
        int   s;
        exp_t e;
        l = (len_cfg[src] > MAXLEN) ? MAXLEN : len_cfg[src];
        s = src + l;
        e = '{dat: HEADER, src: 2'(src), hdr: 1'b1, pay: 1'b0, idx: 4'd0};
        exp_q.push_back(e);
        e = '{dat: 8'(src), src: 2'(src), hdr: 1'b0, pay: 1'b0, idx: 4'd0};
        exp_q.push_back(e);
        e = '{dat: 8'(l), src: 2'(src), hdr: 1'b0, pay: 1'b0, idx: 4'd0};
        exp_q.push_back(e);
        for (int i = 0; i < l; i++) begin
            s += int'(pay_mem[src][i]);
            e = '{dat: pay_mem[src][i], src: 2'(src), hdr: 1'b0, pay: 1'b1, idx: 4'(i)};
            exp_q.push_back(e);
        end
        e = '{dat: 8'(s % 256), src: 2'(src), hdr: 1'b0, pay: 1'b0, idx: 4'd0};
        exp_q.push_back(e);
        done_q.push_back(src);
    endfunction

    // Serve pending sources one frame at a time, always taking the next one at or after the pointer.
    function automatic void plan_round();
        int rem [4];
        bit any;
        rem = rem_cfg;
        any = 1'b1;
        while (any) begin
            any = 1'b0;
            for (int off = 0; off < 4; off++) begin
                int k;
                k = (model_ptr + off) % 4;
                if (rem[k] > 0) begin
                    push_frame(k);
                    rem[k]--;
                    model_ptr = (k + 1) % 4;
                    any = 1'b1;
                    break;
                end
            end
        end
    endfunction

    initial begin : monitor
        exp_t e;
        int   s;
        forever begin
            @(negedge CLK);
            if (RSTn === 1'b1 && WR_Req_sig === 1'b1) begin
                if (exp_q.size() == 0) begin
                    n_vectors++;
                    n_miscompares++;
                    $display("[TB] FAIL unexpected_write: got 0x%0h, expected no write", FIFO_WR_Dat);
                end else begin
                    e = exp_q.pop_front();
                    checkOutput("byte", 32'(FIFO_WR_Dat), 32'(e.dat));
                    checkOutput("grant", 32'(Grant), 32'(4'b0001 << e.src));
                    if (e.pay) checkOutput("rd_idx", 32'(Rd_Idx), 32'(e.idx));
                    if (e.hdr) hdr_cyc_q.push_back(cyc);
                end
            end
            if (RSTn === 1'b1 && Done !== 4'b0000) begin
                done_cyc_q.push_back(cyc);
                if (done_q.size() == 0) begin
                    n_vectors++;
                    n_miscompares++;
                    $display("[TB] FAIL unexpected_done: got 0x%0h, expected none", Done);
                end else begin
                    s = done_q.pop_front();
                    checkOutput("done", 32'(Done), 32'(4'b0001 << s));
                end
            end
        end
    end

    task automatic do_reset();
        RSTn     = 1'b0;
        Req      = 4'b0000;
        Full_sig = 1'b0;
        Len      = 20'd0;
        repeat (3) @(posedge CLK);
        #1;
        checkOutput("rst_grant", 32'(Grant), 32'd0);
        checkOutput("rst_done", 32'(Done), 32'd0);
        checkOutput("rst_rd_idx", 32'(Rd_Idx), 32'd0);
        checkOutput("rst_wr_req", 32'(WR_Req_sig), 32'd0);
        checkOutput("rst_wr_dat", 32'(FIFO_WR_Dat), 32'd0);
        exp_q.delete();
        done_q.delete();
        model_ptr = 0;
        RSTn      = 1'b1;
        @(posedge CLK);
        #1;
    endtask

    // mode 0: FIFO never full, 1: random full, 2: one 5-cycle stall at payload index 1,
    // 3: reset while in payload of source 0, then expect a fresh frame from source 0.
    task automatic applyStimulus(input int mode);
        int t;
        drv_rem = rem_cfg;
        for (int k = 0; k < 4; k++) Len[5*k +: 5] = 5'(len_cfg[k]);
        plan_round();
        hdr_cyc_q.delete();
        done_cyc_q.delete();
        stall_left  = 0;
        stall_done  = 1'b0;
        reset_done  = 1'b0;
        round_start = cyc;
        Full_sig    = 1'b0;
        for (int k = 0; k < 4; k++) Req[k] = (rem_cfg[k] > 0);
        t = 0;
        while (Req != 4'b0000 && t < 3000) begin
            @(negedge CLK);
            t++;
            for (int k = 0; k < 4; k++) begin
                if (Done[k] && drv_rem[k] > 0) begin
                    drv_rem[k]--;
                    if (drv_rem[k] == 0) Req[k] = 1'b0;
                end
            end
            if (stall_left > 0) begin
                checkOutput("stall_wr_req", 32'(WR_Req_sig), 32'd0);
                checkOutput("stall_rd_idx", 32'(Rd_Idx), 32'd1);
                stall_left--;
            end
            @(posedge CLK);
            #1;
            case (mode)
                1: Full_sig = ($urandom_range(0, 3) == 0);
                2: begin
                    if (stall_left > 0) begin
                        Full_sig = 1'b1;
                    end else if (!stall_done && Grant != 4'b0000 && Rd_Idx == 4'd1) begin
                        Full_sig   = 1'b1;
                        stall_left = 5;
                        stall_done = 1'b1;
                    end else begin
                        Full_sig = 1'b0;
                    end
                end
                3: begin
                    if (!reset_done && Grant[0] && Rd_Idx == 4'd3) begin
                        RSTn = 1'b0;
                        #1;
                        checkOutput("midrst_grant", 32'(Grant), 32'd0);
                        checkOutput("midrst_done", 32'(Done), 32'd0);
                        checkOutput("midrst_rd_idx", 32'(Rd_Idx), 32'd0);
                        checkOutput("midrst_wr_req", 32'(WR_Req_sig), 32'd0);
                        checkOutput("midrst_wr_dat", 32'(FIFO_WR_Dat), 32'd0);
                        exp_q.delete();
                        done_q.delete();
                        push_frame(0);
                        model_ptr = 1;
                        @(posedge CLK);
                        #1;
                        RSTn       = 1'b1;
                        reset_done = 1'b1;
                    end
                end
                default: Full_sig = 1'b0;
            endcase
        end
        if (Req != 4'b0000) begin
            n_vectors++;
            n_miscompares++;
            $display("[TB] FAIL round_timeout: Req still 0x%0h after %0d cycles, expected 0", Req, t);
            Req = 4'b0000;
        end
        Full_sig = 1'b0;
        checkOutput("exp_q_drained", 32'(exp_q.size()), 32'd0);
        checkOutput("done_q_drained", 32'(done_q.size()), 32'd0);
    endtask

    initial begin : stimulus
        for (int k = 0; k < 4; k++) begin
            for (int i = 0; i < 16; i++) pay_mem[k][i] = 8'h00;
        end
        do_reset();

        // Single source, Len 3, payload 11 22 33: expect ...,69 and Done 8 cycles after the Req edge.
        len_cfg = '{3, 0, 0, 0};
        rem_cfg = '{1, 0, 0, 0};
        pay_mem[0][0] = 8'h11;
        pay_mem[0][1] = 8'h22;
        pay_mem[0][2] = 8'h33;
        applyStimulus(0);
        checkOutput("hdr_latency", 32'(hdr_cyc_q.size() > 0 ? hdr_cyc_q[0] - round_start : -1), 32'd1);
        checkOutput("done_latency", 32'(done_cyc_q.size() > 0 ? done_cyc_q[0] - round_start : -1), 32'd8);

        // All four held, Len 1: order 0,1,2,3,0 with headers 7 cycles apart.
        do_reset();
        len_cfg = '{1, 1, 1, 1};
        rem_cfg = '{2, 1, 1, 1};
        for (int k = 0; k < 4; k++) pay_mem[k][0] = 8'($urandom);
        applyStimulus(0);
        checkOutput("hdr_count", 32'(hdr_cyc_q.size()), 32'd5);
        for (int i = 1; i < 5; i++) begin
            checkOutput("hdr_spacing", 32'(hdr_cyc_q.size() > i ? hdr_cyc_q[i] - hdr_cyc_q[i-1] : -1), 32'd7);
        end

        // Five-cycle FIFO stall at payload index 1.
        len_cfg = '{3, 0, 0, 0};
        rem_cfg = '{1, 0, 0, 0};
        applyStimulus(2);
        checkOutput("stall_seen", 32'(stall_done), 32'd1);

        // Zero length from source 2, clamped length 20 from source 3.
        len_cfg = '{0, 0, 0, 20};
        rem_cfg = '{0, 0, 1, 1};
        for (int i = 0; i < 16; i++) pay_mem[3][i] = 8'($urandom);
        applyStimulus(0);

        // Checksum wrap: source 1, payload FF FF.
        len_cfg = '{0, 2, 0, 0};
        rem_cfg = '{0, 1, 0, 0};
        pay_mem[1][0] = 8'hFF;
        pay_mem[1][1] = 8'hFF;
        applyStimulus(0);

        // Reset during payload with source 0 still requesting.
        len_cfg = '{8, 0, 0, 0};
        rem_cfg = '{1, 0, 0, 0};
        for (int i = 0; i < 16; i++) pay_mem[0][i] = 8'($urandom);
        applyStimulus(3);
        checkOutput("midrst_seen", 32'(reset_done), 32'd1);

        // Randomized rounds with random FIFO backpressure.
        for (int r = 0; r < 30; r++) begin
            for (int k = 0; k < 4; k++) begin
                rem_cfg[k] = $urandom_range(0, 2);
                len_cfg[k] = $urandom_range(0, 31);
                for (int i = 0; i < 16; i++) pay_mem[k][i] = 8'($urandom);
            end
            if (rem_cfg[0] + rem_cfg[1] + rem_cfg[2] + rem_cfg[3] == 0) rem_cfg[$urandom_range(0, 3)] = 1;
            applyStimulus(1);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vectors, n_miscompares);
        $finish;
    end

    initial begin : watchdog
        #3000000;
        $display("[TB] FAIL watchdog: simulation still running at %0t, expected completion", $time);
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
